mips_trace_capture: RTL and testbench

Trace reader for the single-cycle MIPS core. It samples the core's per-cycle observation buses (pc, inst, alu, data outpins) into an on-chip buffer, starting on a PC-match trigger. It then drains the buffer as a 32-bit valid/ready word stream for a host or bench to consume. It sits beside the CPU wrapper and only observes; it never drives the core.

---
 rtl/mips_trace_capture_if.sv | 35 +++
 rtl/mips_trace_capture.sv | 228 ++++++++++++++++++++++
 tb/tb_mips_trace_capture.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_trace_capture_if.sv
// -----------------------------------------------------------------------------
// mips_trace_capture_if
// Readout stream of the MIPS trace capture block: one 32-bit word per
// handshake, with a marker on the final word of the final trace entry.
//
// Signals:
//   rd_data   32  readout word (producer -> consumer)
//   rd_valid   1  readout word valid (producer -> consumer)
//   rd_ready   1  consumer accepts the word (consumer -> producer)
//   rd_last    1  final word of the final entry (producer -> consumer)
//
// Modports:
//   master  the trace capture block (drives data/valid/last)
//   slave   the host or bench draining the buffer (drives ready)
// -----------------------------------------------------------------------------
interface mips_trace_capture_if;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_ready;
  logic        rd_last;

  modport master (
    output rd_data,
    output rd_valid,
    output rd_last,
    input  rd_ready
  );

  modport slave (
    input  rd_data,
    input  rd_valid,
    input  rd_last,
    output rd_ready
  );
endinterface

// File: rtl/mips_trace_capture.sv
// -----------------------------------------------------------------------------
// mips_trace_capture
// Passive trace reader for the single-cycle MIPS core. After being armed it
// waits for a PC-match trigger (or triggers at once), records the core's
// per-cycle observation buses {pc, inst, alu, data} into a DEPTH-entry buffer,
// and then drains the buffer as a stream of 32-bit words (pc, inst, alu, data
// per entry) over a valid/ready handshake. It never drives the core.
//
// Parameters:
//   DEPTH  number of trace entries (power of 2, >= 2)
//   AW     log2(DEPTH)
//
// Ports:
//   clk       in   1     system clock, all logic on posedge
//   reset     in   1     synchronous active-low reset
//   arm       in   1     start a capture (only honoured in IDLE)
//   trig_en   in   1     1 = wait for pc_in == trig_pc, 0 = trigger at once
//   trig_pc   in   32    trigger PC value
//   stop      in   1     end the capture early (only honoured in CAPTURE)
//   pc_in     in   32    core PC outpin
//   inst_in   in   32    core instruction outpin
//   alu_in    in   32    core ALU result outpin
//   data_in   in   32    core data-memory read outpin
//   busy      out  1     high while ARMED or CAPTURE
//   done      out  1     high while READ
//   count     out  AW+1  number of captured entries
//   rd        master     readout stream (rd_data/rd_valid/rd_ready/rd_last)
// -----------------------------------------------------------------------------
module mips_trace_capture #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 arm,
  input  logic                 trig_en,
  input  logic [31:0]          trig_pc,
  input  logic                 stop,
  input  logic [31:0]          pc_in,
  input  logic [31:0]          inst_in,
  input  logic [31:0]          alu_in,
  input  logic [31:0]          data_in,
  output logic                 busy,
  output logic                 done,
  output logic [AW:0]          count,
  mips_trace_capture_if.master rd
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_READ    = 2'd3
  } state_t;

  // Count value whose next write fills the buffer.
  localparam logic [AW:0]   CNT_FULL_M1 = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0]   CNT_ONE     = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_ZERO    = {(AW+1){1'b0}};
  localparam logic [AW-1:0] PTR_ONE     = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ZERO    = {AW{1'b0}};

  state_t        state_r;
  logic          busy_r;
  logic          done_r;
  logic [AW:0]   count_r;
  logic [AW-1:0] wptr_r;
  logic [AW-1:0] rptr_r;
  logic [1:0]    wsel_r;
  logic [31:0]   rd_data_r;
  logic          rd_valid_r;
  logic          rd_last_r;

  logic [127:0]  mem_r [0:DEPTH-1];

  logic          hit_s;
  logic          wr_en_s;
  logic          fire_s;
  logic [1:0]    nxt_wsel_s;
  logic [AW-1:0] nxt_rptr_s;
  logic          nxt_last_s;

  // Select one 32-bit word of an entry: 0 = pc, 1 = inst, 2 = alu, 3 = data.
  function automatic logic [31:0] entry_word(input logic [127:0] entry,
                                             input logic [1:0]   sel);
    logic [31:0] w;
    case (sel)
      2'd0:    w = entry[127:96];
      2'd1:    w = entry[95:64];
      2'd2:    w = entry[63:32];
      2'd3:    w = entry[31:0];
      default: w = 32'd0;
    endcase
    return w;
  endfunction

  // Trigger match, write enable and readout pointer advance.
  always_comb begin
    hit_s      = 1'b0;
    wr_en_s    = 1'b0;
    fire_s     = 1'b0;
    nxt_wsel_s = wsel_r + 2'd1;
    nxt_rptr_s = rptr_r;
    nxt_last_s = 1'b0;

    hit_s = (trig_en == 1'b0) || (pc_in == trig_pc);

    // Moving past word 3 of an entry steps to the next entry.
    if (wsel_r == 2'd3) begin
      nxt_rptr_s = rptr_r + PTR_ONE;
    end else begin
      nxt_rptr_s = rptr_r;
    end

    nxt_last_s = ({1'b0, nxt_rptr_s} == (count_r - CNT_ONE)) && (nxt_wsel_s == 2'd3);

    case (state_r)
      S_ARMED:   wr_en_s = hit_s;
      S_CAPTURE: wr_en_s = !stop;
      // rd_valid is high for the whole of READ, so ready alone is a handshake.
      S_READ:    fire_s  = rd.rd_ready;
      default: begin
        wr_en_s = 1'b0;
        fire_s  = 1'b0;
      end
    endcase
  end

  // Trace buffer: synchronous write of one full sample per enabled edge.
  always_ff @(posedge clk) begin
    if (reset && wr_en_s) begin
      mem_r[wptr_r] <= {pc_in, inst_in, alu_in, data_in};
    end
  end

  // Capture/readout control FSM with registered status and stream outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= S_IDLE;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      count_r    <= CNT_ZERO;
      wptr_r     <= PTR_ZERO;
      rptr_r     <= PTR_ZERO;
      wsel_r     <= 2'd0;
      rd_data_r  <= 32'd0;
      rd_valid_r <= 1'b0;
      rd_last_r  <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          // count is left alone here so the host can still inspect it.
          if (arm) begin
            state_r <= S_ARMED;
            busy_r  <= 1'b1;
            count_r <= CNT_ZERO;
            wptr_r  <= PTR_ZERO;
          end
        end

        S_ARMED: begin
          // The matching sample itself becomes entry 0.
          if (hit_s) begin
            state_r <= S_CAPTURE;
            count_r <= CNT_ONE;
            wptr_r  <= PTR_ONE;
          end
        end

        S_CAPTURE: begin
          if (stop || (count_r == CNT_FULL_M1)) begin
            // stop suppresses the write even when it would fill the buffer.
            if (!stop) begin
              count_r <= count_r + CNT_ONE;
            end
            state_r    <= S_READ;
            busy_r     <= 1'b0;
            done_r     <= 1'b1;
            rptr_r     <= PTR_ZERO;
            wsel_r     <= 2'd0;
            rd_valid_r <= 1'b1;
            rd_last_r  <= 1'b0;
            // Entry 0 was written on the trigger edge, so it is already stored.
            rd_data_r  <= entry_word(mem_r[PTR_ZERO], 2'd0);
          end else begin
            count_r <= count_r + CNT_ONE;
            wptr_r  <= wptr_r + PTR_ONE;
          end
        end

        S_READ: begin
          if (fire_s) begin
            if (rd_last_r) begin
              state_r    <= S_IDLE;
              done_r     <= 1'b0;
              rd_valid_r <= 1'b0;
              rd_last_r  <= 1'b0;
              rd_data_r  <= 32'd0;
              rptr_r     <= PTR_ZERO;
              wsel_r     <= 2'd0;
            end else begin
              wsel_r    <= nxt_wsel_s;
              rptr_r    <= nxt_rptr_s;
              rd_last_r <= nxt_last_s;
              rd_data_r <= entry_word(mem_r[nxt_rptr_s], nxt_wsel_s);
            end
          end
        end

        default: begin
          state_r    <= S_IDLE;
          busy_r     <= 1'b0;
          done_r     <= 1'b0;
          rd_valid_r <= 1'b0;
          rd_last_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign count       = count_r;
  assign rd.rd_data  = rd_data_r;
  assign rd.rd_valid = rd_valid_r;
  assign rd.rd_last  = rd_last_r;

endmodule

// File: tb/tb_mips_trace_capture.sv
// -----------------------------------------------------------------------------
// tb_mips_trace_capture
// Self-checking bench for mips_trace_capture. A table of capture scenarios is
// applied in a loop; each scenario feeds a running core (PC step 4, random
// inst/alu/data), records the expected buffer contents in a queue from the
// capture rules, and then drains the readout stream with a chosen ready
// pattern, comparing every accepted word against the queue. Hand-written
// sequences cover reset mid-capture and mid-readout.
// -----------------------------------------------------------------------------
module tb_mips_trace_capture;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        arm;
  logic        trig_en;
  logic [31:0] trig_pc;
  logic        stop;
  logic [31:0] pc_in;
  logic [31:0] inst_in;
  logic [31:0] alu_in;
  logic [31:0] data_in;
  logic        busy;
  logic        done;
  logic [AW:0] count;

  mips_trace_capture_if rd_if();

  mips_trace_capture #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk     (clk),
    .reset   (reset),
    .arm     (arm),
    .trig_en (trig_en),
    .trig_pc (trig_pc),
    .stop    (stop),
    .pc_in   (pc_in),
    .inst_in (inst_in),
    .alu_in  (alu_in),
    .data_in (data_in),
    .busy    (busy),
    .done    (done),
    .count   (count),
    .rd      (rd_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        te;
    logic [31:0] tpc;
    logic [31:0] pc0;
    int          stop_after;   // -1: run until full
    int          rmode;        // 0 always ready, 1 pattern 1,0,0, 2 random
    logic        noise;        // random arm (and stop while armed)
    int          exp_count;
    logic [31:0] exp_first_pc;
  } vec_t;

  int checks   = 0;
  int failures = 0;
  logic [127:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_after_reset(input string tag);
    chk({tag, "_busy"},     32'(busy),           32'd0);
    chk({tag, "_done"},     32'(done),           32'd0);
    chk({tag, "_count"},    32'(count),          32'd0);
    chk({tag, "_rd_valid"}, 32'(rd_if.rd_valid), 32'd0);
    chk({tag, "_rd_last"},  32'(rd_if.rd_last),  32'd0);
    chk({tag, "_rd_data"},  rd_if.rd_data,       32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    logic [31:0]  pc;
    logic [127:0] s;
    logic [31:0]  ew;
    logic [31:0]  prev_data;
    logic         trig;
    logic         fin;
    logic         rdy;
    logic         prev_stall;
    int           k;
    int           cyc;
    int           n;
    int           idx;

    exp_q.delete();
    trig_en = v.te;
    trig_pc = v.tpc;
    pc      = v.pc0;
    pc_in   = pc;
    stop    = 1'b0;
    rd_if.rd_ready = 1'b0;
    arm = 1'b1;
    tick();
    arm = 1'b0;

    // Capture phase: the bench decides from the rules which samples get kept.
    trig = 1'b0; fin = 1'b0; k = 0; cyc = 0;
    while (!fin && cyc < 400) begin
      pc_in   = pc;
      inst_in = $urandom();
      alu_in  = $urandom();
      data_in = $urandom();
      s       = {pc_in, inst_in, alu_in, data_in};
      stop    = 1'b0;
      arm     = v.noise ? 1'($urandom_range(0, 1)) : 1'b0;
      chk("cap_busy",  32'(busy),  32'd1);
      chk("cap_done",  32'(done),  32'd0);
      chk("cap_count", 32'(count), 32'(exp_q.size()));
      if (!trig) begin
        if (v.noise) stop = 1'($urandom_range(0, 1));
        if (!v.te || pc_in == v.tpc) begin
          trig = 1'b1;
          exp_q.push_back(s);
          k = 1;
        end
      end else if (k == v.stop_after) begin
        stop = 1'b1;
        fin  = 1'b1;
      end else begin
        exp_q.push_back(s);
        k++;
        if (exp_q.size() == DEPTH) fin = 1'b1;
      end
      tick();
      pc = pc + 32'd4;
      cyc++;
    end
    stop = 1'b0;
    arm  = 1'b0;
    chk("capture_finished", 32'(fin),            32'd1);
    chk("read_done",        32'(done),           32'd1);
    chk("read_busy",        32'(busy),           32'd0);
    chk("read_count_model", 32'(count),          32'(exp_q.size()));
    chk("read_count_table", 32'(count),          32'(v.exp_count));
    chk("read_valid_first", 32'(rd_if.rd_valid), 32'd1);

    // Readout phase.
    n = exp_q.size() * 4; idx = 0; cyc = 0; prev_stall = 1'b0; prev_data = 32'd0;
    while (idx < n && cyc < n * 8 + 64) begin
      case (v.rmode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      rd_if.rd_ready = rdy;
      arm = (v.noise && !(rdy && idx == n - 1)) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (prev_stall) chk("stall_hold", rd_if.rd_data, prev_data);
      chk("rd_valid", 32'(rd_if.rd_valid), 32'd1);
      if (!rd_if.rd_valid) break;
      chk("rd_last", 32'(rd_if.rd_last), 32'(idx == n - 1));
      if (rdy) begin
        s  = exp_q[idx / 4];
        ew = s[(3 - (idx % 4)) * 32 +: 32];
        chk("rd_word", rd_if.rd_data, ew);
        if (idx == 0) chk("first_pc", rd_if.rd_data, v.exp_first_pc);
        idx++;
      end
      prev_stall = !rdy;
      prev_data  = rd_if.rd_data;
      tick();
      cyc++;
    end
    rd_if.rd_ready = 1'b0;
    arm = 1'b0;
    chk("readout_complete", 32'(idx),            32'(n));
    chk("end_rd_valid",     32'(rd_if.rd_valid), 32'd0);
    chk("end_done",         32'(done),           32'd0);
    chk("end_busy",         32'(busy),           32'd0);
    chk("end_count_kept",   32'(count),          32'(v.exp_count));
    tick();
    chk("idle_stays",       32'(busy),           32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [7];
    vecs[0] = '{1'b0, 32'h0000_0000, 32'h0000_0000, -1, 0, 1'b0, 16, 32'h0000_0000};
    vecs[1] = '{1'b1, 32'h0000_0020, 32'h0000_0000, -1, 0, 1'b0, 16, 32'h0000_0020};
    vecs[2] = '{1'b1, 32'h0000_0100, 32'h0000_00C0,  5, 0, 1'b0,  5, 32'h0000_0100};
    vecs[3] = '{1'b0, 32'h0000_0000, 32'h0000_0400, 15, 0, 1'b0, 15, 32'h0000_0400};
    vecs[4] = '{1'b0, 32'h0000_0000, 32'h0000_0080,  1, 1, 1'b0,  1, 32'h0000_0080};
    vecs[5] = '{1'b1, 32'h1000_0010, 32'h1000_0000, -1, 2, 1'b1, 16, 32'h1000_0010};
    vecs[6] = '{1'b1, 32'h0000_0044, 32'h0000_0040,  9, 1, 1'b1,  9, 32'h0000_0044};

    reset = 1'b0; arm = 1'b0; trig_en = 1'b0; trig_pc = 32'd0; stop = 1'b0;
    pc_in = 32'd0; inst_in = 32'd0; alu_in = 32'd0; data_in = 32'd0;
    rd_if.rd_ready = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    chk_idle_after_reset("por");
    tick();
    chk("por_idle_busy", 32'(busy), 32'd0);

    // Reset mid-capture with seven entries stored.
    trig_en = 1'b0;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    repeat (7) begin
      pc_in = $urandom();
      tick();
    end
    chk("midcap_count", 32'(count), 32'd7);
    chk("midcap_busy",  32'(busy),  32'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk_idle_after_reset("rst_cap");

    // Reset mid-readout after a stopped three-entry capture.
    arm = 1'b1;
    tick();
    arm = 1'b0;
    repeat (3) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("midread_done",  32'(done),  32'd1);
    chk("midread_count", 32'(count), 32'd3);
    rd_if.rd_ready = 1'b1;
    tick();
    tick();
    rd_if.rd_ready = 1'b0;
    chk("midread_valid", 32'(rd_if.rd_valid), 32'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk_idle_after_reset("rst_read");

    // Table-driven capture/readout scenarios; each one re-arms from IDLE.
    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
